ped_req_cond: RTL and testbench

Pedestrian request conditioner: the stage directly upstream of the traffic-light controller top, generating its `N` (pedestrian request) input. It synchronises and debounces the raw crossing push-button and latches one request until the controller serves it (pedestrian green `Pg` fed back). After each service it enforces a hold-off window, drives a "WAIT" lamp, and counts served requests.

---
 rtl/ped_req_cond.sv | 142 ++++++++++++++
 tb/tb_ped_req_cond.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_req_cond.sv
// Pedestrian request conditioner: sync/debounce the crossing button,
// latch one request until pedestrian green, then hold off and count.
module ped_req_cond #(
    parameter int DEB_CYCLES = 4,
    parameter int HOLDOFF    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       pg,
    output logic       N,
    output logic       wait_lamp,
    output logic [7:0] served_cnt
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_SERV,
        S_HOLD
    } state_t;

    state_t        state;
    state_t        nxt;
    logic          s1;
    logic          s2;
    logic          db;
    logic          db_d;
    logic [DW-1:0] dcnt;
    logic          press;
    logic [HW-1:0] hcnt;
    logic          early;
    logic          early_nxt;
    logic          hold_done;
    logic          serv_end;
    logic          n_nxt;
    logic          wait_nxt;

    // Two-flop synchroniser, then level debounce on the synced sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            db_d <= 1'b0;
            dcnt <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_d <= db;
            if (s2 != db) begin
                if (dcnt == DEB_LAST) begin
                    db   <= s2;
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
            end else begin
                dcnt <= '0;
            end
        end
    end

    assign press     = db && !db_d;
    assign hold_done = (state == S_HOLD) && (hcnt == '0);
    assign serv_end  = (state == S_SERV) && !pg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (press && !pg) begin
                    nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (pg) begin
                    nxt = S_SERV;
                end
            end
            S_SERV: begin
                if (!pg) begin
                    nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hcnt == '0) begin
                    nxt = (early || press) ? S_PEND : S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // A press during service or hold-off is remembered until hold-off ends.
    always_comb begin
        early_nxt = early;
        if (hold_done) begin
            early_nxt = 1'b0;
        end else if (press && (state == S_SERV || state == S_HOLD)) begin
            early_nxt = 1'b1;
        end
        n_nxt    = (nxt == S_PEND);
        wait_nxt = n_nxt || early_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hcnt       <= '0;
            early      <= 1'b0;
            served_cnt <= '0;
            N          <= 1'b0;
            wait_lamp  <= 1'b0;
        end else begin
            early     <= early_nxt;
            N         <= n_nxt;
            wait_lamp <= wait_nxt;
            if (serv_end) begin
                hcnt <= HOLD_LOAD;
            end else if (state == S_HOLD && hcnt != '0) begin
                hcnt <= hcnt - HW'(1);
            end
            if (serv_end && served_cnt != 8'hff) begin
                served_cnt <= served_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ped_req_cond.sv
// Directed bench for ped_req_cond: reset, debounce, service cycle,
// early press, mid-operation reset and counter saturation.
module tb_ped_req_cond;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       pg;
    logic       N;
    logic       wait_lamp;
    logic [7:0] served_cnt;

    int         checks;
    int         fails;
    logic [7:0] exp_srv;

    ped_req_cond #(
        .DEB_CYCLES(4),
        .HOLDOFF   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .pg        (pg),
        .N         (N),
        .wait_lamp (wait_lamp),
        .served_cnt(served_cnt)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        btn = 1'b0;
        pg  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        btn = 1'b1;
        pg  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (N !== 1'b0 || wait_lamp !== 1'b0 || served_cnt !== 8'd0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: N=%b wait=%b cnt=%0d, need 0/0/0",
                         i, N, wait_lamp, served_cnt);
            end
        end
        rst = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step();
            checks++;
            if (N !== (e >= 6)) begin
                fails++;
                $display("FAIL reset_release_N[e%0d]: got %b need %b", e, N, (e >= 6));
            end
        end
        rst = 1'b0;
        btn = 1'b0;
        step();
        rst = 1'b1;
        exp_srv = 8'd0;
        idle(10);
    endtask

    task automatic test_bounce;
        logic [11:0] pat;
        pat = 12'b0000_1110_0111;
        for (int e = 0; e < 30; e++) begin
            btn = (e < 12) ? pat[e] : 1'b0;
            step();
            checks++;
            if (N !== 1'b0 || wait_lamp !== 1'b0 || served_cnt !== exp_srv) begin
                fails++;
                $display("FAIL bounce[e%0d]: N=%b wait=%b cnt=%0d, need 0/0/%0d",
                         e, N, wait_lamp, served_cnt, exp_srv);
            end
        end
    endtask

    task automatic test_clean_cycle;
        logic en;
        for (int e = 0; e < 46; e++) begin
            btn = (e <= 15);
            pg  = (e >= 20 && e < 30);
            step();
            if (e == 30) exp_srv = exp_srv + 8'd1;
            en = (e >= 6 && e <= 19);
            checks++;
            if (N !== en || wait_lamp !== en || served_cnt !== exp_srv) begin
                fails++;
                $display("FAIL clean[e%0d]: N=%b wait=%b cnt=%0d, need %b/%b/%0d",
                         e, N, wait_lamp, served_cnt, en, en, exp_srv);
            end
        end
        pg = 1'b0;
    endtask

    task automatic test_early_press;
        logic en;
        logic ew;
        for (int e = 0; e < 61; e++) begin
            btn = (e <= 15) || (e >= 27 && e <= 40);
            pg  = (e >= 20 && e < 30) || (e == 45) || (e == 46);
            step();
            if (e == 30 || e == 47) exp_srv = exp_srv + 8'd1;
            en = (e >= 6 && e <= 19) || (e >= 38 && e <= 44);
            ew = (e >= 6 && e <= 19) || (e >= 33 && e <= 44);
            checks++;
            if (N !== en || wait_lamp !== ew || served_cnt !== exp_srv) begin
                fails++;
                $display("FAIL early[e%0d]: N=%b wait=%b cnt=%0d, need %b/%b/%0d",
                         e, N, wait_lamp, served_cnt, en, ew, exp_srv);
            end
        end
        pg = 1'b0;
    endtask

    task automatic test_mid_reset;
        for (int e = 0; e < 8; e++) begin
            btn = 1'b1;
            step();
            checks++;
            if (N !== (e >= 6)) begin
                fails++;
                $display("FAIL midrst_pend[e%0d]: got %b need %b", e, N, (e >= 6));
            end
        end
        btn = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_srv = 8'd0;
        checks++;
        if (N !== 1'b0 || wait_lamp !== 1'b0 || served_cnt !== 8'd0) begin
            fails++;
            $display("FAIL midrst_edge: N=%b wait=%b cnt=%0d, need 0/0/0",
                     N, wait_lamp, served_cnt);
        end
        for (int e = 0; e < 20; e++) begin
            step();
            checks++;
            if (N !== 1'b0 || wait_lamp !== 1'b0) begin
                fails++;
                $display("FAIL midrst_idle[e%0d]: N=%b wait=%b, need 0/0",
                         e, N, wait_lamp);
            end
        end
    endtask

    task automatic test_saturation;
        logic found;
        for (int i = 0; i < 260; i++) begin
            btn   = 1'b1;
            found = 1'b0;
            for (int k = 0; k < 20; k++) begin
                step();
                if (N === 1'b1) begin
                    found = 1'b1;
                    break;
                end
            end
            checks++;
            if (!found) begin
                fails++;
                $display("FAIL sat_req[%0d]: N stayed %b, need 1 within 20 edges", i, N);
            end
            btn = 1'b0;
            pg  = 1'b1;
            step();
            checks++;
            if (N !== 1'b0) begin
                fails++;
                $display("FAIL sat_serve[%0d]: N=%b need 0", i, N);
            end
            pg = 1'b0;
            step();
            exp_srv = (exp_srv == 8'd255) ? 8'd255 : exp_srv + 8'd1;
            checks++;
            if (served_cnt !== exp_srv) begin
                fails++;
                $display("FAIL sat_cnt[%0d]: got %0d need %0d", i, served_cnt, exp_srv);
            end
            idle(14);
        end
        checks++;
        if (served_cnt !== 8'd255) begin
            fails++;
            $display("FAIL sat_final: got %0d need 255", served_cnt);
        end
    endtask

    task automatic test_pg_idle;
        btn = 1'b0;
        pg  = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step();
            checks++;
            if (N !== 1'b0 || wait_lamp !== 1'b0 || served_cnt !== exp_srv) begin
                fails++;
                $display("FAIL pg_idle[e%0d]: N=%b wait=%b cnt=%0d, need 0/0/%0d",
                         e, N, wait_lamp, served_cnt, exp_srv);
            end
        end
        pg = 1'b0;
        for (int e = 0; e < 12; e++) begin
            step();
            checks++;
            if (N !== 1'b0 || served_cnt !== exp_srv) begin
                fails++;
                $display("FAIL pg_idle_after[e%0d]: N=%b cnt=%0d, need 0/%0d",
                         e, N, served_cnt, exp_srv);
            end
        end
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b0;
        btn     = 1'b0;
        pg      = 1'b0;
        checks  = 0;
        fails   = 0;
        exp_srv = 8'd0;
        #2;
        test_reset();
        test_bounce();
        test_clean_cycle();
        test_early_press();
        test_mid_reset();
        test_saturation();
        test_pg_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
